// File: rtl/freq_meter.sv
// freq_meter: gated edge-counting frequency meter.
// Counts synchronized rising edges of sig_in over a window of GATE_CYCLES
// reference-clock cycles and reports the result with a one-cycle valid strobe.
// Single-shot (start) and back-to-back (continuous) measurement are supported.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 continuous,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 valid,
  output logic                 busy,
  output logic                 overflow
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   rise;

  logic [GW-1:0]          gate_cnt;
  logic [CNT_WIDTH-1:0]   edge_cnt;
  logic                   sticky;

  logic                   open_win;
  logic                   last;
  logic                   restart;
  logic                   at_max;
  logic [CNT_WIDTH-1:0]   final_cnt;
  logic                   final_ovf;

  // Synchronize the asynchronous input and keep one history bit for edge detection.
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update together from pre-edge values, which is what makes the shift chain work.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: open a window on request, close it after the last gate
  // cycle unless continuous mode asks for another one.
  // NOTE: the default assignment at the top keeps this process free of latches
  // on any path that does not assign state_next explicitly.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start || continuous)   state_next = GATE;
      GATE:    if (last && !continuous)   state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  // Control decode: window open/close events and the final count of a window,
  // including a rise that lands on the last gate cycle.
  always_comb begin
    open_win  = (state == IDLE) && (start || continuous);
    last      = (state == GATE) && (gate_cnt == GATE_LAST);
    restart   = open_win || (last && continuous);
    at_max    = (edge_cnt == {CNT_WIDTH{1'b1}});
    final_cnt = (rise && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
    final_ovf = sticky || (rise && at_max);
  end

  // Gate and edge counters; the edge counter saturates and latches overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sticky   <= 1'b0;
    end else if (restart) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sticky   <= 1'b0;
    end else if (state == GATE && !last) begin
      gate_cnt <= gate_cnt + 1'b1;
      if (rise) begin
        if (at_max) sticky   <= 1'b1;
        else        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  // Registered outputs: result capture on the last gate cycle, strobe and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= last;
      busy  <= (state_next == GATE);
      if (last) begin
        count    <= final_cnt;
        overflow <= final_ovf;
      end
    end
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gated edge-counting frequency meter. It counts rising edges of an asynchronous input over a fixed window of reference-clock cycles and presents the result with a one-cycle valid strobe. It is the measuring end of the frequency-counter chain: the input is typically a divided-down signal from the prescaler, and the result feeds the display or readout logic. It supports single-shot and back-to-back (continuous) measurement.

## Interface
- `GATE_CYCLES`, default 100000000: window length in `clk` cycles; legal range ≥ 2.
- `CNT_WIDTH`, default 32: width of the edge counter and of the result.
- `SYNC_STAGES`, default 2: synchronizer depth on `sig_in`; legal range ≥ 2.

Ports:
- `clk`  in  1  reference clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sig_in`  in  1  signal under measurement; asynchronous to `clk`.
- `start`  in  1  request one measurement; sampled only in IDLE.
- `continuous`  in  1  when high, windows repeat back-to-back; in IDLE it acts like `start`.
- `count`  out  CNT_WIDTH  rising-edge count of the last completed window; held until the next result.
- `valid`  out  1  one-cycle strobe: `count` and `overflow` were just updated.
- `busy`  out  1  high while a window is open.
- `overflow`  out  1  the last completed window saturated the edge counter.

## Operation
- Input path:
  - `sig_in` passes through a `SYNC_STAGES`-flop synchronizer, then one history flop.
  - `rise` = synced & ~history.
  - Resolvable input frequency is below f_clk/2. Higher rates alias and are not flagged.
- State machine, two states:
  - **IDLE**: `busy` = 0. When `start | continuous` is high, clear the edge counter, clear the sticky overflow, clear the gate counter, and go to GATE.
  - **GATE**: `busy` = 1.
    - The gate counter counts 0..GATE_CYCLES-1. Its width is $clog2(GATE_CYCLES).
    - Each cycle with `rise` = 1 increments the edge counter.
    - On the last gate cycle (gate counter = GATE_CYCLES-1):
      - Load `count` with the final edge count, including a `rise` in that same cycle.
      - Load `overflow` from the sticky flag.
      - Pulse `valid`.
    - After the last gate cycle: if `continuous` = 1, stay in GATE and restart the window with the edge counter reset to 0. If `continuous` = 0, go to IDLE.
- Saturation:
  - The edge counter stops at 2^CNT_WIDTH-1.
  - A `rise` while the counter is saturated sets the sticky overflow flag.
  - The counter never wraps.
- `start` while `busy` is ignored; there is no queueing.
- Dropping `continuous` mid-window finishes the current window, reports it, then returns to IDLE.
- Reset, including mid-window:
  - Synchronizer, history, counters, state → IDLE.
  - `count` = 0, `valid` = 0, `busy` = 0, `overflow` = 0.
  - The in-progress window is discarded and produces no `valid`.
- After reset the synchronizer holds 0. If `sig_in` is high, one rise is detected SYNC_STAGES+1 cycles later. It is counted only if a window is open by then. A window started within the first SYNC_STAGES+1 cycles after reset may therefore include one spurious edge. Readout logic discards the first result after reset.

## Timing
- Start to window:
  - `start` high at rising edge k (in IDLE) → `busy` = 1 from cycle k+1.
  - The window covers cycles k+1 .. k+GATE_CYCLES, i.e. exactly GATE_CYCLES cycles of `rise`.
- Result: `valid` = 1 during cycle k+GATE_CYCLES+1, with the new `count`/`overflow`.
- Single-shot turnaround:
  - `busy` = 0 in cycle k+GATE_CYCLES+1.
  - A `start` sampled at that edge opens the next window at k+GATE_CYCLES+2, one dead cycle.
- Continuous mode:
  - Windows are contiguous, with no dead cycle.
  - `valid` strobes are exactly GATE_CYCLES cycles apart.
  - `busy` stays high.
  - No rise is lost or double-counted at window boundaries.
- Input latency: a `sig_in` rising transition is reflected in `rise` SYNC_STAGES+1 cycles later, ±1 cycle for metastability resolution.
- All outputs are registered.

## Test plan
Parameters GATE_CYCLES=100, CNT_WIDTH=8, SYNC_STAGES=2 unless stated.
- **Reset**: assert `rst` 3 cycles with `sig_in` toggling → `count`=0, `valid`=0, `busy`=0, `overflow`=0 throughout and on the cycle after release.
- **Single shot**: `sig_in` period 10 clk (5 high/5 low), one-cycle `start` at k → `busy` high for cycles k+1..k+100; exactly one `valid`, at k+101, with `count`=10 and `overflow`=0; `busy`=0 afterwards.
- **Max rate**: `sig_in` toggles every clk → `count`=50.
- **Saturation** (CNT_WIDTH=4): `sig_in` period 4 → `count`=15, `overflow`=1. Next window with `sig_in` period 20 → `count`=5, `overflow`=0.
- **Continuous**: `continuous` high for 5 windows, `sig_in` with random period 3–40 → `valid` strobes exactly 100 cycles apart; sum of counts equals edges injected across the spanned cycles (offset by the sync latency). Drop `continuous` mid-window 5 → that window still reports, then `busy`=0.
- **Abort / ignore**:
  - Pulse `start` at window cycle 30 → no effect.
  - Assert `rst` at window cycle 50 → `busy`=0 next cycle, no `valid`, `count`=0.
  - A following `start` yields a normal full-window result.
